// File: rtl/cdb_pkg.sv
// Common data bus definitions shared by the CDB broadcaster, ROB entries and
// reservation stations: bus widths, the "no producer" tag and the mapping from
// execution-unit index to the tag it broadcasts.
package cdb_pkg;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;

    // Tag 0 means "no producer"; it never appears on the bus with cdb_valid=1.
    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    // Execution unit i broadcasts with tag i+1 so that tag 0 stays reserved.
    function automatic logic [TAG_W-1:0] src_to_tag(input int i);
        return TAG_W'(i + 1);
    endfunction

endpackage

// File: rtl/cdb_broadcaster_rr_arbiter.sv
// Round-robin arbiter used by the CDB broadcaster. Purely combinational: the
// request at index ptr has the highest priority, the search wraps from N-1
// back to 0, and exactly one grant bit is set whenever any request is present.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             any
);

    // Scan from lowest to highest priority so the last hit (closest to ptr) wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt_idx = idx[PTR_W-1:0];
                any     = 1'b1;
            end
        end
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// Transmit side of the common data bus. Each execution unit owns one holding
// register; one held result per cycle is chosen round-robin and broadcast as
// {cdb_valid, cdb_tag, cdb_value} from registers (no combinational src->cdb path).
// A granted source is ready again in the same cycle, so a lone source streams
// one result per cycle.
// Optional build macro CDB_STATS_EN adds the stat_bcast / stat_stall counters.
module cdb_broadcaster
    import cdb_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic [N_SRC*DATA_W-1:0] src_value,
    output logic [N_SRC-1:0]        src_ready,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [DATA_W-1:0]       cdb_value
`ifdef CDB_STATS_EN
    ,
    output logic [31:0]             stat_bcast,
    output logic [31:0]             stat_stall
`endif
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]  r_held;
    logic [DATA_W-1:0] r_hold [N_SRC];
    logic [PTR_W-1:0]  r_ptr;
    logic              r_cdb_valid;
    logic [TAG_W-1:0]  r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_value;

    logic [N_SRC-1:0]  w_gnt;
    logic [PTR_W-1:0]  w_gnt_idx;
    logic              w_any;
    logic [N_SRC-1:0]  w_accept;
    logic [N_SRC-1:0]  w_held_next;
    logic [DATA_W-1:0] w_value [N_SRC];

    rr_arbiter #(
        .N     (N_SRC),
        .PTR_W (PTR_W)
    ) u_arb (
        .req     (r_held),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    // A slot is free when empty or when its content leaves on the bus this cycle.
    assign src_ready = ~r_held | w_gnt;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            assign w_value[gi]     = src_value[gi*DATA_W +: DATA_W];
            assign w_accept[gi]    = src_valid[gi] & src_ready[gi];
            // A refill wins over the grant-clear so streaming keeps the slot full.
            assign w_held_next[gi] = w_accept[gi] | (r_held[gi] & ~w_gnt[gi]);
        end
    endgenerate

    // Holding registers: capture accepted results, drop them on grant or flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_held <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            r_held <= flush ? '0 : w_held_next;
            for (int i = 0; i < N_SRC; i++) begin
                if (w_accept[i] && !flush) begin
                    r_hold[i] <= w_value[i];
                end
            end
        end
    end

    // Round-robin pointer: advance past the winner; a flush leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_any && !flush) begin
            r_ptr <= (w_gnt_idx == PTR_W'(N_SRC - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // Bus output registers: tag and value are forced to zero whenever not valid.
    always_ff @(posedge clk) begin
        if (!rst_n || flush || !w_any) begin
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= TAG_NONE;
            r_cdb_value <= '0;
        end else begin
            r_cdb_valid <= 1'b1;
            r_cdb_tag   <= src_to_tag(int'(w_gnt_idx));
            r_cdb_value <= r_hold[w_gnt_idx];
        end
    end

    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_value = r_cdb_value;

`ifdef CDB_STATS_EN
    logic [31:0] r_stat_bcast;
    logic [31:0] r_stat_stall;
    logic        w_stall;

    assign w_stall = |(src_valid & ~src_ready);

    // Statistics: count loaded broadcasts and cycles with any backpressured source.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_bcast <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_any && !flush) begin
                r_stat_bcast <= r_stat_bcast + 32'd1;
            end
            if (w_stall) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_bcast = r_stat_bcast;
    assign stat_stall = r_stat_stall;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster. Expected broadcasts are queued when
// stimulus is driven; a monitor pops and compares them whenever the bus is valid
// and checks that the bus is all-zero when idle.
module tb_cdb_broadcaster;
    import cdb_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                flush;
    logic [N-1:0]        src_valid;
    logic [N*DATA_W-1:0] src_value;
    logic [N-1:0]        src_ready;
    logic                cdb_valid;
    logic [TAG_W-1:0]    cdb_tag;
    logic [DATA_W-1:0]   cdb_value;
`ifdef CDB_STATS_EN
    logic [31:0]         stat_bcast;
    logic [31:0]         stat_stall;
`endif

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    cdb_broadcaster #(.N_SRC(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .src_valid (src_valid),
        .src_value (src_value),
        .src_ready (src_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value)
`ifdef CDB_STATS_EN
        ,
        .stat_bcast (stat_bcast),
        .stat_stall (stat_stall)
`endif
    );

    // Scoreboard monitor: one line per broadcast, compare against queue head.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (cdb_valid === 1'b1) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_bcast: got tag=%0d value=%h, required no broadcast", cdb_tag, cdb_value);
                end else begin
                    e = sb_q.pop_front();
                    if (cdb_tag !== e.tag || cdb_value !== e.value) begin
                        n_bad++;
                        $display("FAIL bcast: got tag=%0d value=%h, required tag=%0d value=%h", cdb_tag, cdb_value, e.tag, e.value);
                    end else begin
                        $display("bcast tag=%0d value=%h ok", cdb_tag, cdb_value);
                    end
                end
            end else begin
                n_cmp++;
                if (cdb_valid !== 1'b0 || cdb_tag !== TAG_NONE || cdb_value !== '0) begin
                    n_bad++;
                    $display("FAIL idle_zero: got valid=%b tag=%0d value=%h, required 0/0/0", cdb_valid, cdb_tag, cdb_value);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [DATA_W-1:0] v);
        src_value[i*DATA_W +: DATA_W] = v;
    endtask

    task automatic push_exp(input int i, input logic [DATA_W-1:0] v);
        exp_t e;
        e.tag   = src_to_tag(i);
        e.value = v;
        sb_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (sb_q.size() > 0 && k < budget) begin
            step();
            k++;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending, required 0", sb_q.size());
            sb_q.delete();
        end
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        src_valid = '1;
        src_value = {$urandom, $urandom, $urandom, $urandom};
        step();
        step();
        n_cmp++;
        if (cdb_valid !== 1'b0 || cdb_tag !== TAG_NONE) begin
            n_bad++;
            $display("FAIL reset_cdb: got valid=%b tag=%0d, required 0/0", cdb_valid, cdb_tag);
        end
        rst_n     = 1'b1;
        src_valid = '0;
        mon_en    = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (src_ready !== 4'hF || cdb_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready: got ready=%h valid=%b, required F/0", src_ready, cdb_valid);
        end
        $display("reset done");
        step();
    endtask

    task automatic test_contention();
        src_valid = '1;
        for (int i = 0; i < N; i++) begin
            set_src(i, 32'hC0C0_0000 | 32'(i));
            push_exp(i, 32'hC0C0_0000 | 32'(i));
        end
        step();
        // src0 re-offers while its first result is being granted: refill accepted,
        // but its broadcast comes only after tag 4.
        src_valid = 4'b0001;
        set_src(0, 32'hC0C0_00AA);
        push_exp(0, 32'hC0C0_00AA);
        @(negedge clk);
        n_cmp++;
        if (src_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL contention_ready0: got %b, required 0001", src_ready);
        end
        step();
        src_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (src_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL contention_full: got %b, required 0010", src_ready);
        end
        drain(20);
    endtask

    task automatic test_single();
        src_valid = 4'b0010;
        set_src(1, 32'hDEAD_BEEF);
        push_exp(1, 32'hDEAD_BEEF);
        step();
        src_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (cdb_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_early: got valid=%b, required 0", cdb_valid);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 4'd2) begin
            n_bad++;
            $display("FAIL single_latency: got valid=%b tag=%0d, required 1/2", cdb_valid, cdb_tag);
        end
        drain(5);
    endtask

    task automatic test_streaming();
        for (int k = 1; k <= 8; k++) begin
            src_valid = 4'b1000;
            set_src(3, 32'(k));
            push_exp(3, 32'(k));
            @(negedge clk);
            n_cmp++;
            if (src_ready[3] !== 1'b1) begin
                n_bad++;
                $display("FAIL stream_ready: got %b at value %0d, required 1", src_ready[3], k);
            end
            if (k >= 3) begin
                n_cmp++;
                if (cdb_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL stream_gap: got valid=%b at value %0d, required 1", cdb_valid, k);
                end
            end
            step();
        end
        src_valid = '0;
        drain(10);
    endtask

    task automatic test_flush();
        // Three results held, none expected on the bus.
        src_valid = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            set_src(i, 32'hF1F1_0000 | 32'(i));
        end
        step();
        // Same-cycle accept from src3 is discarded by the flush.
        src_valid = 4'b1000;
        set_src(3, 32'hF1F1_0003);
        flush     = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (src_ready !== 4'b1001) begin
            n_bad++;
            $display("FAIL flush_ready: got %b, required 1001", src_ready);
        end
        step();
        flush     = 1'b0;
        src_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (cdb_valid !== 1'b0 || src_ready !== 4'hF) begin
            n_bad++;
            $display("FAIL flush_clear: got valid=%b ready=%h, required 0/F", cdb_valid, src_ready);
        end
        for (int k = 0; k < 10; k++) step();
    endtask

    task automatic test_reset_mid();
        src_valid = 4'b0011;
        set_src(0, 32'hAAAA_0000);
        set_src(1, 32'hAAAA_0001);
        step();
        src_valid = '0;
        rst_n     = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cdb_valid !== 1'b0 || src_ready !== 4'hF) begin
            n_bad++;
            $display("FAIL reset_mid: got valid=%b ready=%h, required 0/F", cdb_valid, src_ready);
        end
        for (int k = 0; k < 6; k++) step();
    endtask

`ifdef CDB_STATS_EN
    task automatic test_stats();
        int blocked = 0;
        n_cmp++;
        if (stat_bcast !== 32'd0 || stat_stall !== 32'd0) begin
            n_bad++;
            $display("FAIL stats_reset: got bcast=%0d stall=%0d, required 0/0", stat_bcast, stat_stall);
        end
        src_valid = '1;
        for (int i = 0; i < N; i++) begin
            set_src(i, 32'h5757_0000 | 32'(i));
            push_exp(i, 32'h5757_0000 | 32'(i));
        end
        step();
        src_valid = 4'b0001;
        set_src(0, 32'h5757_00AA);
        push_exp(0, 32'h5757_00AA);
        step();
        // Third src0 result: blocked while tags 2,3,4 go out (3 cycles).
        set_src(0, 32'h5757_00BB);
        push_exp(0, 32'h5757_00BB);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (src_ready[0] === 1'b1) break;
            blocked++;
            step();
        end
        step();
        src_valid = '0;
        drain(20);
        n_cmp++;
        if (blocked != 3) begin
            n_bad++;
            $display("FAIL stats_blocked: got %0d, required 3", blocked);
        end
        n_cmp++;
        if (stat_bcast !== 32'd6 || stat_stall !== 32'd3) begin
            n_bad++;
            $display("FAIL stats_count: got bcast=%0d stall=%0d, required 6/3", stat_bcast, stat_stall);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_streaming();
        test_flush();
        test_reset_mid();
`ifdef CDB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
